// File: rtl/kalman_fp_pkg.sv
// kalman_fp_pkg: shared binary64 constants and sequencing types for the Kalman CMU datapath
package kalman_fp_pkg;
  localparam int DBL_WIDTH = 64;
  localparam logic [DBL_WIDTH-1:0] FP64_ZERO = 64'h0000_0000_0000_0000;
  localparam logic [DBL_WIDTH-1:0] FP64_ONE  = 64'h3FF0_0000_0000_0000;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_e;
  typedef logic [2:0] step_t;
  localparam step_t LAST_STEP = 3'd4;
endpackage

// File: rtl/fp_multiplier.sv
// fp_multiplier: binary64 multiply with a valid/finish handshake; finish holds until valid drops
// Normal operands only; zero exponents yield signed zero, round-to-nearest-even.
module fp_multiplier #(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        valid,
  output logic        finish,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result
);
  logic [105:0] prod;
  logic [10:0]  exp_r;
  logic [51:0]  frac;
  logic         hi;
  logic         g;
  logic         s;
  logic         sign;
  logic [63:0]  result_d;
  logic [7:0]   cnt_q;
  always_comb begin
    prod     = {1'b1, a[51:0]} * {1'b1, b[51:0]};
    hi       = prod[105];
    sign     = a[63] ^ b[63];
    exp_r    = a[62:52] + b[62:52] - 11'd1023 + {10'b0, hi};
    frac     = hi ? prod[104:53] : prod[103:52];
    g        = hi ? prod[52] : prod[51];
    s        = hi ? |prod[51:0] : |prod[50:0];
    // rounding carry ripples naturally from the fraction into the exponent
    result_d = (a[62:52] == 11'd0 || b[62:52] == 11'd0) ? {sign, 63'b0}
             : {sign, exp_r, frac} + {63'b0, g & (s | frac[0])};
  end
  always_ff @(posedge clk) begin
    if (!valid) begin
      cnt_q  <= 8'd0;
      finish <= 1'b0;
    end else if (!finish) begin
      if (cnt_q == 8'(LAT - 1)) begin
        finish <= 1'b1;
        result <= result_d;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end
endmodule

// File: rtl/cmu_dt_power_gen.sv
// cmu_dt_power_gen: computes dt^1..dt^6 through one shared fp_multiplier on a fixed 5-step schedule
// and holds the set with a valid level and a done pulse.
module cmu_dt_power_gen
  import kalman_fp_pkg::*;
#(
  parameter int NUM_POW = 6,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DBL_WIDTH-1:0] dt,
  output logic                 ready,
  output logic [DBL_WIDTH-1:0] delta_t1,
  output logic [DBL_WIDTH-1:0] delta_t2,
  output logic [DBL_WIDTH-1:0] delta_t3,
  output logic [DBL_WIDTH-1:0] delta_t4,
  output logic [DBL_WIDTH-1:0] delta_t5,
  output logic [DBL_WIDTH-1:0] delta_t6,
  output logic                 valid_out,
  output logic                 done
);
  state_e               state_q, state_d;
  step_t                step_q, step_d;
  logic [DBL_WIDTH-1:0] t_q [1:NUM_POW];
  logic [DBL_WIDTH-1:0] t_d [1:NUM_POW];
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 mul_valid;
  logic                 mul_finish;
  logic [DBL_WIDTH-1:0] mul_a, mul_b, mul_result;
  assign mul_valid = state_q == ISSUE || state_q == WAIT;
  // t2=t1*t1, t3=t2*t1, t4=t2*t2, t5=t4*t1, t6=t3*t3
  assign mul_a = step_q == 3'd0 ? t_q[1] : step_q == 3'd3 ? t_q[4] : step_q == 3'd4 ? t_q[3] : t_q[2];
  assign mul_b = step_q == 3'd2 ? t_q[2] : step_q == 3'd4 ? t_q[3] : t_q[1];
  fp_multiplier #(.LAT(MUL_LAT)) u_mul (
    .clk    (clk),
    .valid  (mul_valid),
    .finish (mul_finish),
    .a      (mul_a),
    .b      (mul_b),
    .result (mul_result)
  );
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    t_d     = t_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        t_d[1]  = dt;
        valid_d = 1'b0;
        step_d  = 3'd0;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (mul_finish) begin
        t_d[int'(step_q) + 2] = mul_result;
        state_d = GAP;
      end
      GAP: if (!mul_finish) begin
        valid_d = step_q == LAST_STEP;
        done_d  = step_q == LAST_STEP;
        step_d  = step_q == LAST_STEP ? step_q : step_q + 3'd1;
        state_d = step_q == LAST_STEP ? IDLE : ISSUE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 1; i <= NUM_POW; i++) t_q[i] <= FP64_ZERO;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      t_q     <= t_d;
    end
  end
  assign ready     = state_q == IDLE;
  assign valid_out = valid_q;
  assign done      = done_q;
  assign delta_t1  = t_q[1];
  assign delta_t2  = t_q[2];
  assign delta_t3  = t_q[3];
  assign delta_t4  = t_q[4];
  assign delta_t5  = t_q[5];
  assign delta_t6  = t_q[6];
endmodule

// File: tb/tb_cmu_dt_power_gen.sv
// tb_cmu_dt_power_gen: directed and random dt runs checked against real-arithmetic power model
module tb_cmu_dt_power_gen;
  import kalman_fp_pkg::*;
  localparam int LMUL = 3;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] dt;
  logic        ready, valid_out, done;
  logic [63:0] delta_t1, delta_t2, delta_t3, delta_t4, delta_t5, delta_t6;
  logic [63:0] obs [1:6];
  logic [63:0] exp_t [1:6];
  int          checks = 0;
  int          errors = 0;
  int          lat_ref = -1;

  always #5 clk = ~clk;

  cmu_dt_power_gen #(.MUL_LAT(LMUL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dt        (dt),
    .ready     (ready),
    .delta_t1  (delta_t1),
    .delta_t2  (delta_t2),
    .delta_t3  (delta_t3),
    .delta_t4  (delta_t4),
    .delta_t5  (delta_t5),
    .delta_t6  (delta_t6),
    .valid_out (valid_out),
    .done      (done)
  );

  assign obs[1] = delta_t1;
  assign obs[2] = delta_t2;
  assign obs[3] = delta_t3;
  assign obs[4] = delta_t4;
  assign obs[5] = delta_t5;
  assign obs[6] = delta_t6;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Powers follow the product chain of the schedule so rounding matches exactly.
  task automatic model(input logic [63:0] d);
    real r1, r2, r3, r4, r5, r6;
    r1 = $bitstoreal(d);
    r2 = r1 * r1;
    r3 = r2 * r1;
    r4 = r2 * r2;
    r5 = r4 * r1;
    r6 = r3 * r3;
    exp_t[1] = d;
    exp_t[2] = $realtobits(r2);
    exp_t[3] = $realtobits(r3);
    exp_t[4] = $realtobits(r4);
    exp_t[5] = $realtobits(r5);
    exp_t[6] = $realtobits(r6);
  endtask

  task automatic run(input string name, input logic [63:0] d, input bit poke);
    int cyc, txn;
    bit prev, poked;
    chk({name, " ready_pre"}, {63'b0, ready}, 64'd1);
    model(d);
    start = 1'b1;
    dt = d;
    @(negedge clk);
    start = 1'b0;
    dt = {$urandom, $urandom};
    chk({name, " valid_drop"}, {63'b0, valid_out}, 64'd0);
    chk({name, " ready_busy"}, {63'b0, ready}, 64'd0);
    cyc = 1; txn = 0; prev = 1'b0; poked = 1'b0;
    while (!done && cyc < 4000) begin
      start = 1'b0;
      if (dut.mul_valid && !prev) txn++;
      prev = dut.mul_valid;
      if (poke && !poked && dut.state_q == WAIT && dut.step_q == 3'd1) begin
        start = 1'b1;
        dt = 64'h4014000000000000;
        poked = 1'b1;
        chk({name, " ready_in_wait"}, {63'b0, ready}, 64'd0);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({name, " done"}, {63'b0, done}, 64'd1);
    chk({name, " valid_set"}, {63'b0, valid_out}, 64'd1);
    chk({name, " mul_txns"}, 64'(txn), 64'd5);
    chk({name, " lat_min"}, {63'b0, cyc >= 5 * (LMUL + 3) + 1}, 64'd1);
    if (lat_ref < 0) lat_ref = cyc;
    else chk({name, " latency"}, 64'(cyc), 64'(lat_ref));
    for (int i = 1; i <= 6; i++) chk($sformatf("%s t%0d", name, i), obs[i], exp_t[i]);
    @(negedge clk);
    chk({name, " done_pulse"}, {63'b0, done}, 64'd0);
    chk({name, " valid_hold"}, {63'b0, valid_out}, 64'd1);
    chk({name, " ready_post"}, {63'b0, ready}, 64'd1);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    start = 1'b0;
    dt = 64'h0;
    #1;
    for (int i = 1; i <= 6; i++) chk($sformatf("reset t%0d", i), obs[i], FP64_ZERO);
    chk("reset valid", {63'b0, valid_out}, 64'd0);
    chk("reset done", {63'b0, done}, 64'd0);
    chk("reset ready", {63'b0, ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run("two", 64'h4000000000000000, 1'b0);
    chk("two t6 const", delta_t6, 64'h4050000000000000);
    run("half", 64'h3FE0000000000000, 1'b0);
    chk("half t6 const", delta_t6, 64'h3F90000000000000);
    run("one", FP64_ONE, 1'b0);
    chk("one t6 const", delta_t6, 64'h3FF0000000000000);
    run("three", 64'h4008000000000000, 1'b0);
    chk("three t6 const", delta_t6, 64'h4086C80000000000);
    run("ignored_start", 64'h401C000000000000, 1'b1);

    start = 1'b1;
    dt = 64'h4022000000000000;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(dut.state_q == WAIT && dut.step_q == 3'd2) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst reach step", {61'b0, dut.step_q}, 64'd2);
    rst_n = 1'b0;
    #1;
    for (int i = 1; i <= 6; i++) chk($sformatf("midrst t%0d", i), obs[i], FP64_ZERO);
    chk("midrst valid", {63'b0, valid_out}, 64'd0);
    chk("midrst ready", {63'b0, ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("after_rst", 64'h4000000000000000, 1'b0);
    run("zero", FP64_ZERO, 1'b0);

    for (int k = 0; k < 8; k++) begin
      logic [63:0] rd;
      rd = {1'($urandom), 11'(993 + $urandom_range(0, 60)), 20'($urandom), $urandom};
      run($sformatf("rand%0d", k), rd, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
